// File: rtl/thunderbird_turn_fsm.sv
// Thunderbird tail-light sequencer: synchronises the slow divider tick and the turn/hazard switches,
// then steps a Moore FSM once per tick rising edge to drive six lamps.
module thunderbird_turn_fsm #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clk_In,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic       Left,
  input  logic       Right,
  input  logic       Haz,
  output logic       LA,
  output logic       LB,
  output logic       LC,
  output logic       RA,
  output logic       RB,
  output logic       RC,
  output logic [2:0] State,
  output logic       Tick_Pulse
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_e;

  logic [3:0]                   in_vec;
  logic [SYNC_STAGES-1:0][3:0]  sync_q;
  logic                         tick_prev_q;
  logic                         tick_s, left_s, right_s, haz_s;
  state_e                       state_q, state_d;
  logic [5:0]                   lamps_q, lamps_d;

  assign in_vec = {Haz, Right, Left, Tick};
  assign {haz_s, right_s, left_s, tick_s} = sync_q[SYNC_STAGES-1];

  // Reset preloads every stage and the history flop with the live level, so a Tick
  // already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge Clk_In) begin
    if (!Rst_n) begin
      sync_q      <= {SYNC_STAGES{in_vec}};
      tick_prev_q <= Tick;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], in_vec};
      tick_prev_q <= tick_s;
    end
  end

  assign Tick_Pulse = tick_s & ~tick_prev_q;

  always_comb begin
    state_d = state_q;
    if (Tick_Pulse) begin
      case (state_q)
        IDLE: begin
          if (haz_s || (left_s && right_s)) state_d = LR3;
          else if (left_s)                  state_d = L1;
          else if (right_s)                 state_d = R1;
          else                              state_d = IDLE;
        end
        L1:  state_d = haz_s ? LR3 : L2;
        L2:  state_d = haz_s ? LR3 : L3;
        L3:  state_d = IDLE;
        R1:  state_d = haz_s ? LR3 : R2;
        R2:  state_d = haz_s ? LR3 : R3;
        R3:  state_d = IDLE;
        LR3: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lamp order {LC,LB,LA,RA,RB,RC}; decoded from next state so lamps move with State.
  always_comb begin
    lamps_d = '0;
    case (state_d)
      IDLE: lamps_d = 6'b000_000;
      L1:   lamps_d = 6'b001_000;
      L2:   lamps_d = 6'b011_000;
      L3:   lamps_d = 6'b111_000;
      R1:   lamps_d = 6'b000_100;
      R2:   lamps_d = 6'b000_110;
      R3:   lamps_d = 6'b000_111;
      LR3:  lamps_d = 6'b111_111;
      default: lamps_d = '0;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      lamps_q <= '0;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
    end
  end

  assign State = state_q;
  assign {LC, LB, LA, RA, RB, RC} = lamps_q;

endmodule
